// File: rtl/jogo_sequencia_param.sv
// ============================================================================
// Module : jogo_sequencia_param
// Brief  : memory-sequence game engine ("Genius") - FSM, sequence RAM, round/address counters and play timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module jogo_sequencia_param #(
    parameter int NUM_BOTOES     = 4,
    parameter int PROF_MEM       = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int MOSTRA_CICLOS  = 1000,
    localparam int ADDR_W        = $clog2(PROF_MEM)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jogar,
    input  logic                  nivel,
    input  logic [NUM_BOTOES-1:0] botoes,
    input  logic                  carrega_en,
    input  logic [ADDR_W-1:0]     carrega_end,
    input  logic [NUM_BOTOES-1:0] carrega_dado,
    output logic [NUM_BOTOES-1:0] leds,
    output logic                  pronto,
    output logic                  ganhou,
    output logic                  perdeu,
    output logic                  db_timeout,
    output logic [3:0]            db_estado,
    output logic [ADDR_W-1:0]     db_rodada,
    output logic [ADDR_W-1:0]     db_endereco,
    output logic [NUM_BOTOES-1:0] db_jogada
);

    localparam int MAX_CICLOS = (TIMEOUT_CICLOS > MOSTRA_CICLOS) ? TIMEOUT_CICLOS : MOSTRA_CICLOS;
    localparam int TIMER_W    = $clog2(MAX_CICLOS + 1);

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        PREPARA      = 4'h1,
        MOSTRA_LED   = 4'h2,
        MOSTRA_APAGA = 4'h3,
        ZERA_END     = 4'h4,
        ESPERA       = 4'h5,
        REGISTRA     = 4'h6,
        COMPARA      = 4'h7,
        PROX_JOGADA  = 4'h8,
        PROX_RODADA  = 4'h9,
        FIM_GANHOU   = 4'hA,
        FIM_PERDEU   = 4'hB,
        FIM_TIMEOUT  = 4'hC
    } estado_t;

    estado_t                 estado, prox_estado;
    logic [NUM_BOTOES-1:0]   mem [PROF_MEM];
    logic [NUM_BOTOES-1:0]   mem_dado;
    logic [NUM_BOTOES-1:0]   botoes_q;
    logic [NUM_BOTOES-1:0]   jogada;
    logic [ADDR_W-1:0]       rodada;
    logic [ADDR_W-1:0]       endereco;
    logic [ADDR_W-1:0]       limite_m1;
    logic [TIMER_W-1:0]      timer;
    logic                    nivel_q;

    logic jogada_ev;
    logic ocioso;
    logic fim_mostra;
    logic fim_espera;
    logic jogada_ok;
    logic rod_clr, rod_inc, end_clr, end_inc, tim_clr, tim_inc;
    logic reg_jogada, latch_nivel;

    assign mem_dado   = mem[endereco];
    assign jogada_ev  = (botoes != '0) && (botoes_q == '0);
    assign ocioso     = (estado == INICIAL) || (estado == FIM_GANHOU) ||
                        (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
    assign fim_mostra = (timer == TIMER_W'(MOSTRA_CICLOS - 1));
    assign fim_espera = (timer == TIMER_W'(TIMEOUT_CICLOS - 1));
    assign limite_m1  = nivel_q ? ADDR_W'(PROF_MEM - 1) : ADDR_W'(PROF_MEM / 2 - 1);
    // A play must be exactly one button to count, whatever the RAM holds
    assign jogada_ok  = (jogada != '0) && ((jogada & (jogada - 1'b1)) == '0) &&
                        (jogada == mem_dado);

    always_ff @(posedge clock) begin
        if (carrega_en && ocioso) begin
            mem[carrega_end] <= carrega_dado;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        rod_clr     = 1'b0;
        rod_inc     = 1'b0;
        end_clr     = 1'b0;
        end_inc     = 1'b0;
        tim_clr     = 1'b0;
        tim_inc     = 1'b0;
        reg_jogada  = 1'b0;
        latch_nivel = 1'b0;
        leds        = '0;

        case (estado)
            INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                if (jogar) begin
                    prox_estado = PREPARA;
                    latch_nivel = 1'b1;
                end
            end
            PREPARA: begin
                rod_clr     = 1'b1;
                end_clr     = 1'b1;
                tim_clr     = 1'b1;
                prox_estado = MOSTRA_LED;
            end
            MOSTRA_LED: begin
                leds = mem_dado;
                if (fim_mostra) begin
                    tim_clr     = 1'b1;
                    prox_estado = MOSTRA_APAGA;
                end else begin
                    tim_inc = 1'b1;
                end
            end
            MOSTRA_APAGA: begin
                if (fim_mostra) begin
                    tim_clr = 1'b1;
                    if (endereco == rodada) begin
                        prox_estado = ZERA_END;
                    end else begin
                        end_inc     = 1'b1;
                        prox_estado = MOSTRA_LED;
                    end
                end else begin
                    tim_inc = 1'b1;
                end
            end
            ZERA_END: begin
                end_clr     = 1'b1;
                tim_clr     = 1'b1;
                prox_estado = ESPERA;
            end
            ESPERA: begin
                leds = botoes;
                if (jogada_ev) begin
                    prox_estado = REGISTRA;
                end else if (fim_espera) begin
                    prox_estado = FIM_TIMEOUT;
                end else begin
                    tim_inc = 1'b1;
                end
            end
            REGISTRA: begin
                reg_jogada  = 1'b1;
                prox_estado = COMPARA;
            end
            COMPARA: begin
                if (!jogada_ok) begin
                    prox_estado = FIM_PERDEU;
                end else if (endereco != rodada) begin
                    prox_estado = PROX_JOGADA;
                end else if (rodada == limite_m1) begin
                    prox_estado = FIM_GANHOU;
                end else begin
                    prox_estado = PROX_RODADA;
                end
            end
            PROX_JOGADA: begin
                end_inc     = 1'b1;
                tim_clr     = 1'b1;
                prox_estado = ESPERA;
            end
            PROX_RODADA: begin
                rod_inc     = 1'b1;
                end_clr     = 1'b1;
                tim_clr     = 1'b1;
                prox_estado = MOSTRA_LED;
            end
            default: prox_estado = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            botoes_q <= '0;
            jogada   <= '0;
            rodada   <= '0;
            endereco <= '0;
            timer    <= '0;
            nivel_q  <= 1'b0;
        end else begin
            botoes_q <= botoes;
            if (latch_nivel) begin
                nivel_q <= nivel;
            end
            if (rod_clr) begin
                rodada <= '0;
            end else if (rod_inc) begin
                rodada <= rodada + 1'b1;
            end
            if (end_clr) begin
                endereco <= '0;
            end else if (end_inc) begin
                endereco <= endereco + 1'b1;
            end
            if (tim_clr) begin
                timer <= '0;
            end else if (tim_inc) begin
                timer <= timer + 1'b1;
            end
            if (reg_jogada) begin
                jogada <= botoes;
            end
        end
    end

    assign pronto      = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
    assign ganhou      = (estado == FIM_GANHOU);
    assign perdeu      = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
    assign db_timeout  = (estado == FIM_TIMEOUT);
    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_endereco = endereco;
    assign db_jogada   = jogada;

endmodule

`default_nettype wire

// File: tb/tb_jogo_sequencia_param.sv
// ============================================================================
// Module : tb_jogo_sequencia_param
// Brief  : directed self-checking bench for jogo_sequencia_param (4 buttons, depth 4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_jogo_sequencia_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       jogar;
    logic       nivel;
    logic [3:0] botoes;
    logic       carrega_en;
    logic [1:0] carrega_end;
    logic [3:0] carrega_dado;
    logic [3:0] leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;
    logic [1:0] db_rodada;
    logic [1:0] db_endereco;
    logic [3:0] db_jogada;

    int checks = 0;
    int errors = 0;

    logic [3:0] seq [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
    logic [3:0] cap [8];
    int         ncap;

    jogo_sequencia_param #(
        .NUM_BOTOES    (4),
        .PROF_MEM      (4),
        .TIMEOUT_CICLOS(20),
        .MOSTRA_CICLOS (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .jogar       (jogar),
        .nivel       (nivel),
        .botoes      (botoes),
        .carrega_en  (carrega_en),
        .carrega_end (carrega_end),
        .carrega_dado(carrega_dado),
        .leds        (leds),
        .pronto      (pronto),
        .ganhou      (ganhou),
        .perdeu      (perdeu),
        .db_timeout  (db_timeout),
        .db_estado   (db_estado),
        .db_rodada   (db_rodada),
        .db_endereco (db_endereco),
        .db_jogada   (db_jogada)
    );

    always #5 clock = ~clock;

    // Stimulus helpers: all of them start and end on a falling edge.
    task automatic wait_estado(input logic [3:0] st, input int budget);
        int n = 0;
        while (db_estado !== st && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (db_estado !== st) begin
            checks++;
            errors++;
            $display("FAIL wait_estado: state %0h, required %0h within %0d cycles", db_estado, st, budget);
        end
    endtask

    task automatic start(input logic lvl);
        @(negedge clock);
        nivel = lvl;
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    // Records the pattern shown at each entry into MOSTRA_LED until ESPERA.
    task automatic capture();
        logic [3:0] prev;
        int n = 0;
        ncap = 0;
        prev = db_estado;
        while (db_estado !== 4'h5 && n < 200) begin
            @(negedge clock);
            n++;
            if (db_estado == 4'h2 && prev != 4'h2) begin
                if (ncap < 8) cap[ncap] = leds;
                ncap++;
            end
            prev = db_estado;
        end
        if (db_estado !== 4'h5) begin
            checks++;
            errors++;
            $display("FAIL capture: state %0h, required 5 within 200 cycles", db_estado);
        end
    endtask

    task automatic play(input logic [3:0] v);
        wait_estado(4'h5, 100);
        botoes = v;
        @(negedge clock);
        @(negedge clock);
        botoes = 4'b0000;
    endtask

    task automatic load_ram();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            carrega_en   = 1'b1;
            carrega_end  = 2'(i);
            carrega_dado = seq[i];
        end
        @(negedge clock);
        carrega_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; jogar = 1'b0; nivel = 1'b0; botoes = 4'b0;
        carrega_en = 1'b0; carrega_end = 2'd0; carrega_dado = 4'd0;
        repeat (2) @(negedge clock);
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_estado: got %0h, required 0", db_estado); end
        checks++; if ({leds, pronto, ganhou, perdeu, db_timeout} !== 8'h00) begin errors++; $display("FAIL reset_flags: leds %0h p%0b g%0b l%0b t%0b, required all 0", leds, pronto, ganhou, perdeu, db_timeout); end
        checks++; if ({db_rodada, db_endereco, db_jogada} !== 8'h00) begin errors++; $display("FAIL reset_counters: rod %0d end %0d jog %0h, required 0", db_rodada, db_endereco, db_jogada); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL idle_hold: got %0h, required 0", db_estado); end
    endtask

    task automatic test_win_nivel1();
        start(1'b1);
        for (int r = 0; r < 4; r++) begin
            capture();
            checks++; if (ncap !== r + 1) begin errors++; $display("FAIL win1_len r%0d: got %0d, required %0d", r, ncap, r + 1); end
            for (int i = 0; i <= r; i++) begin
                checks++; if (cap[i] !== seq[i]) begin errors++; $display("FAIL win1_led r%0d i%0d: got %0h, required %0h", r, i, cap[i], seq[i]); end
            end
            for (int i = 0; i <= r; i++) play(seq[i]);
        end
        @(negedge clock);
        checks++; if (db_estado !== 4'hA) begin errors++; $display("FAIL win1_estado: got %0h, required A", db_estado); end
        checks++; if ({ganhou, pronto, perdeu} !== 3'b110) begin errors++; $display("FAIL win1_flags: g%0b p%0b l%0b, required g1 p1 l0", ganhou, pronto, perdeu); end
        checks++; if (db_rodada !== 2'd3 || db_endereco !== 2'd3) begin errors++; $display("FAIL win1_counters: rod %0d end %0d, required 3 3", db_rodada, db_endereco); end
        repeat (5) @(negedge clock);
        checks++; if (ganhou !== 1'b1 || db_estado !== 4'hA) begin errors++; $display("FAIL win1_hold: g%0b estado %0h, required 1 A", ganhou, db_estado); end
    endtask

    task automatic test_win_nivel0();
        start(1'b0);
        for (int r = 0; r < 2; r++) begin
            capture();
            for (int i = 0; i <= r; i++) play(seq[i]);
        end
        @(negedge clock);
        checks++; if (db_estado !== 4'hA || ganhou !== 1'b1) begin errors++; $display("FAIL win0: estado %0h g%0b, required A 1", db_estado, ganhou); end
        checks++; if (db_rodada !== 2'd1) begin errors++; $display("FAIL win0_rodada: got %0d, required 1", db_rodada); end
    endtask

    task automatic test_wrong_play();
        start(1'b1);
        capture();
        play(4'd1);
        capture();
        play(4'd1);
        play(4'b0100);
        @(negedge clock);
        checks++; if (db_estado !== 4'hB) begin errors++; $display("FAIL wrong_estado: got %0h, required B", db_estado); end
        checks++; if ({perdeu, ganhou, pronto, db_timeout} !== 4'b1010) begin errors++; $display("FAIL wrong_flags: l%0b g%0b p%0b t%0b, required 1 0 1 0", perdeu, ganhou, pronto, db_timeout); end
        checks++; if (db_jogada !== 4'd4) begin errors++; $display("FAIL wrong_jogada: got %0h, required 4", db_jogada); end
    endtask

    task automatic test_timeout();
        start(1'b1);
        capture();
        repeat (19) @(negedge clock);
        checks++; if (db_estado !== 4'h5) begin errors++; $display("FAIL timeout_early: estado %0h after 19 cycles, required 5", db_estado); end
        @(negedge clock);
        checks++; if (db_estado !== 4'hC) begin errors++; $display("FAIL timeout_estado: got %0h, required C", db_estado); end
        checks++; if ({db_timeout, perdeu, pronto, ganhou} !== 4'b1110) begin errors++; $display("FAIL timeout_flags: t%0b l%0b p%0b g%0b, required 1 1 1 0", db_timeout, perdeu, pronto, ganhou); end
    endtask

    task automatic test_multibit();
        start(1'b1);
        capture();
        play(4'b0011);
        @(negedge clock);
        checks++; if (db_estado !== 4'hB || perdeu !== 1'b1) begin errors++; $display("FAIL multibit: estado %0h l%0b, required B 1", db_estado, perdeu); end
        checks++; if (db_jogada !== 4'b0011) begin errors++; $display("FAIL multibit_jogada: got %0h, required 3", db_jogada); end
    endtask

    task automatic test_ev_at_timeout();
        start(1'b1);
        capture();
        repeat (19) @(negedge clock);
        botoes = 4'b0001;
        #1;
        checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL espera_echo: leds %0h, required 1", leds); end
        @(negedge clock);
        checks++; if (db_estado !== 4'h6) begin errors++; $display("FAIL ev_priority: got %0h, required 6", db_estado); end
        @(negedge clock);
        botoes = 4'b0000;
        @(negedge clock);
        checks++; if (db_estado !== 4'h9) begin errors++; $display("FAIL ev_next_round: got %0h, required 9", db_estado); end
    endtask

    task automatic test_reset_mid();
        wait_estado(4'h2, 50);
        checks++; if (leds !== 4'd1) begin errors++; $display("FAIL mid_leds: got %0h, required 1", leds); end
        #2 reset = 1'b1;
        #1;
        checks++; if (db_estado !== 4'h0 || leds !== 4'h0) begin errors++; $display("FAIL async_reset: estado %0h leds %0h, required 0 0", db_estado, leds); end
        checks++; if ({pronto, ganhou, perdeu, db_timeout, db_rodada, db_endereco, db_jogada} !== 12'h000) begin errors++; $display("FAIL async_reset_regs: rod %0d end %0d jog %0h, required 0", db_rodada, db_endereco, db_jogada); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_ram_protect();
        start(1'b0);
        capture();
        carrega_en   = 1'b1;
        carrega_end  = 2'd0;
        carrega_dado = 4'd8;
        jogar        = 1'b1;
        @(negedge clock);
        carrega_en = 1'b0;
        jogar      = 1'b0;
        checks++; if (db_estado !== 4'h5) begin errors++; $display("FAIL jogar_ignored: got %0h, required 5", db_estado); end
        play(4'd1);
        capture();
        checks++; if (ncap !== 2 || cap[0] !== 4'd1 || cap[1] !== 4'd2) begin errors++; $display("FAIL ram_protect: n%0d seq %0h %0h, required 2 1 2", ncap, cap[0], cap[1]); end
        play(4'd1);
        play(4'd2);
        @(negedge clock);
        checks++; if (db_estado !== 4'hA || ganhou !== 1'b1) begin errors++; $display("FAIL protect_win: estado %0h g%0b, required A 1", db_estado, ganhou); end
    endtask

    initial begin
        test_reset();
        load_ram();
        test_win_nivel1();
        test_win_nivel0();
        test_wrong_play();
        test_timeout();
        test_multibit();
        test_ev_at_timeout();
        test_reset_mid();
        test_ram_protect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
